// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART core: FSM encodings, oversample default
// and the baud divider calculation.
package uart_pkg;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

   localparam int OVS_DEF = 16;

   // Rounded clock divider giving OVS ticks per bit.
   function automatic int calc_div(input longint f, input longint b, input longint ovs);
      return int'((f + (b * ovs) / 2) / (b * ovs));
   endfunction

endpackage

// File: rtl/uart_baudgen.sv
// Free-running divider: counts 0..DIV-1 and pulses tick_o for one cycle at DIV-1.
module uart_baudgen #(
   parameter int DIV = 1
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tick_o
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == LAST);
   assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_txrx_core.sv
// 8N1 full-duplex UART core: oversampled receiver and transmitter sharing one
// baud tick; tx_wr/rx_ack are level inputs qualified on their rising edge.
module uart_txrx_core
   import uart_pkg::*;
#(
   parameter int freq_hz = 25000000,
   parameter int baud    = 115200,
   parameter int OVS     = OVS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   output logic       rx_error,
   input  logic       rx_ack,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_busy
);

   localparam int DIV = calc_div(freq_hz, baud, OVS);
   localparam int TW  = $clog2(OVS);
   localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
   localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);

   generate
      if (DIV < 1 || OVS < 8 || (OVS & (OVS - 1)) != 0) begin : g_param_chk
         $error("uart_txrx_core: DIV must be >= 1 and OVS a power of 2 >= 8");
      end
   endgenerate

   logic tick;

   uart_baudgen #(.DIV(DIV)) u_baudgen (
      .clk_i  (clk),
      .rst_ni (rst),
      .tick_o (tick)
   );

   // arm_q blocks edges for the first cycle after reset so held levels don't fire.
   logic [1:0] sync_q;
   logic       arm_q, wr_q, ack_q;
   logic       rxs, wr_edge, ack_edge;

   assign rxs      = sync_q[1];
   assign wr_edge  = arm_q & tx_wr  & ~wr_q;
   assign ack_edge = arm_q & rx_ack & ~ack_q;

   rx_state_e     rx_st_q, rx_st_d;
   logic [TW-1:0] rx_tc_q, rx_tc_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic          rx_brk_q, rx_brk_d, rx_avail_q, rx_avail_d, rx_err_q, rx_err_d;

   tx_state_e     tx_st_q, tx_st_d;
   logic [TW-1:0] tx_tc_q, tx_tc_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_sh_q, tx_sh_d;
   logic          txd_q, txd_d, tx_busy_q, tx_busy_d;

   always_comb begin
      rx_st_d    = rx_st_q;
      rx_tc_d    = rx_tc_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_brk_d   = rx_brk_q;
      rx_data_d  = rx_data_q;
      rx_avail_d = rx_avail_q;
      rx_err_d   = rx_err_q;
      if (ack_edge) begin
         rx_avail_d = 1'b0;
         rx_err_d   = 1'b0;
      end
      case (rx_st_q)
         RX_IDLE: if (!rxs) begin
            rx_st_d = RX_START;
            rx_tc_d = '0;
         end
         RX_START: if (tick) begin
            if (rx_tc_q == T_HALF) begin
               rx_tc_d  = '0;
               rx_bit_d = '0;
               rx_st_d  = rxs ? RX_IDLE : RX_DATA;
            end else begin
               rx_tc_d = rx_tc_q + 1'b1;
            end
         end
         RX_DATA: if (tick) begin
            rx_tc_d = rx_tc_q + 1'b1;
            if (rx_tc_q == T_LAST) begin
               rx_sh_d  = {rxs, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 1'b1;
               if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
         end
         RX_STOP: begin
            // After a bad stop bit, hold here until the line idles so a break isn't a new start.
            if (rx_brk_q) begin
               if (rxs) begin
                  rx_brk_d = 1'b0;
                  rx_st_d  = RX_IDLE;
               end
            end else if (tick) begin
               rx_tc_d = rx_tc_q + 1'b1;
               if (rx_tc_q == T_LAST) begin
                  rx_data_d = rx_sh_q;
                  if (rxs) begin
                     rx_err_d   = rx_err_q | rx_avail_q;
                     rx_avail_d = 1'b1;
                     rx_st_d    = RX_IDLE;
                  end else begin
                     rx_err_d   = 1'b1;
                     rx_avail_d = rx_avail_q;
                     rx_brk_d   = 1'b1;
                  end
               end
            end
         end
         default: rx_st_d = RX_IDLE;
      endcase
   end

   // Each TX level is driven on the first tick of its state, so every bit lasts OVS ticks.
   always_comb begin
      tx_st_d   = tx_st_q;
      tx_tc_d   = tx_tc_q;
      tx_bit_d  = tx_bit_q;
      tx_sh_d   = tx_sh_q;
      txd_d     = txd_q;
      tx_busy_d = tx_busy_q;
      case (tx_st_q)
         TX_IDLE: if (wr_edge) begin
            tx_sh_d   = tx_data;
            tx_busy_d = 1'b1;
            tx_tc_d   = '0;
            tx_st_d   = TX_START;
         end
         TX_START: if (tick) begin
            tx_tc_d = tx_tc_q + 1'b1;
            if (tx_tc_q == '0) txd_d = 1'b0;
            if (tx_tc_q == T_LAST) begin
               tx_bit_d = '0;
               tx_st_d  = TX_DATA;
            end
         end
         TX_DATA: if (tick) begin
            tx_tc_d = tx_tc_q + 1'b1;
            if (tx_tc_q == '0) txd_d = tx_sh_q[0];
            if (tx_tc_q == T_LAST) begin
               tx_sh_d  = {1'b0, tx_sh_q[7:1]};
               tx_bit_d = tx_bit_q + 1'b1;
               if (tx_bit_q == 3'd7) tx_st_d = TX_STOP;
            end
         end
         TX_STOP: if (tick) begin
            tx_tc_d = tx_tc_q + 1'b1;
            if (tx_tc_q == '0) txd_d = 1'b1;
            if (tx_tc_q == T_LAST) begin
               tx_busy_d = 1'b0;
               tx_st_d   = TX_IDLE;
            end
         end
         default: tx_st_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q     <= 2'b11;
         arm_q      <= 1'b0;
         wr_q       <= 1'b0;
         ack_q      <= 1'b0;
         rx_st_q    <= RX_IDLE;
         rx_tc_q    <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_brk_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_avail_q <= 1'b0;
         rx_err_q   <= 1'b0;
         tx_st_q    <= TX_IDLE;
         tx_tc_q    <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         txd_q      <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], uart_rxd};
         arm_q      <= 1'b1;
         wr_q       <= tx_wr;
         ack_q      <= rx_ack;
         rx_st_q    <= rx_st_d;
         rx_tc_q    <= rx_tc_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_brk_q   <= rx_brk_d;
         rx_data_q  <= rx_data_d;
         rx_avail_q <= rx_avail_d;
         rx_err_q   <= rx_err_d;
         tx_st_q    <= tx_st_d;
         tx_tc_q    <= tx_tc_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         txd_q      <= txd_d;
         tx_busy_q  <= tx_busy_d;
      end
   end

   assign uart_txd = txd_q;
   assign rx_data  = rx_data_q;
   assign rx_avail = rx_avail_q;
   assign rx_error = rx_err_q;
   assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_uart_txrx_core.sv
// Directed + randomized bench for uart_txrx_core at 16 clocks per bit, with a
// frame-level receive model and a bit-time waveform check of the transmitter.
module tb_uart_txrx_core;

   logic       clk = 1'b0, rst = 1'b0;
   logic       rxd_drv = 1'b1, loop = 1'b0;
   logic       rx_ack = 1'b0, tx_wr = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       uart_rxd, uart_txd, rx_avail, rx_error, tx_busy;
   logic [7:0] rx_data;

   int n_cmp = 0, n_err = 0;

   // Receive-side model: last byte, byte-waiting and error flags.
   logic [7:0] m_data  = 8'h00;
   logic       m_avail = 1'b0, m_err = 1'b0;

   assign uart_rxd = loop ? uart_txd : rxd_drv;

   always #5 clk = ~clk;

   uart_txrx_core #(.freq_hz(1600000), .baud(100000)) dut (
      .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .uart_txd(uart_txd),
      .rx_data(rx_data), .rx_avail(rx_avail), .rx_error(rx_error), .rx_ack(rx_ack),
      .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stopv);
      logic [9:0] f;
      f = {stopv, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd_drv = f[i];
         clk_n(16);
      end
      rxd_drv = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] b, input logic stopv);
      m_data = b;
      if (stopv) begin
         m_err   = m_err | m_avail;
         m_avail = 1'b1;
      end else begin
         m_err = 1'b1;
      end
   endtask

   task automatic check_rx(input string tag);
      chk({tag, "_data"},  32'(rx_data),  32'(m_data));
      chk({tag, "_avail"}, 32'(rx_avail), 32'(m_avail));
      chk({tag, "_err"},   32'(rx_error), 32'(m_err));
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      clk_n(1);
      m_avail = 1'b0;
      m_err   = 1'b0;
      chk("ack_avail", 32'(rx_avail), 32'(m_avail));
      chk("ack_err",   32'(rx_error), 32'(m_err));
      rx_ack = 1'b0;
      clk_n(1);
   endtask

   initial begin
      logic       wav [200];
      logic       bsy [200];
      logic [9:0] fr;
      logic [7:0] b;
      int         n0, cnt, ok;

      // Reset behaviour, including a tx_wr level already high at release.
      clk_n(3);
      for (int i = 0; i < 6; i++) begin
         rxd_drv = ~rxd_drv;
         clk_n(2);
      end
      rxd_drv = 1'b1;
      chk("rst_txd",   32'(uart_txd), 1);
      chk("rst_busy",  32'(tx_busy),  0);
      check_rx("rst");
      tx_wr = 1'b1;
      clk_n(1);
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         clk_n(1);
         if (!uart_txd || tx_busy) cnt++;
      end
      chk("rst_held_wr_no_tx", 32'(cnt), 0);
      tx_wr = 1'b0;
      clk_n(2);

      // Transmit 8'hA5, with a second tx_wr edge mid-frame that must be dropped.
      tx_data = 8'hA5;
      tx_wr   = 1'b1;
      for (int i = 0; i < 200; i++) begin
         clk_n(1);
         wav[i] = uart_txd;
         bsy[i] = tx_busy;
         if (i == 60) tx_wr = 1'b0;
         if (i == 62) tx_wr = 1'b1;
      end
      tx_wr = 1'b0;
      n0 = -1;
      for (int i = 0; i < 200; i++) if (n0 < 0 && !wav[i]) n0 = i;
      chk("tx_start_seen", 32'(n0 >= 0 && n0 <= 16), 1);
      if (n0 < 0 || n0 > 16) n0 = 0;
      fr = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) chk($sformatf("tx_bit%0d", k), 32'(wav[n0 + 16*k + 8]), 32'(fr[k]));
      cnt = 0;
      while (n0 + cnt < 200 && !wav[n0 + cnt]) cnt++;
      chk("tx_start_len", 32'(cnt), 16);
      cnt = 0;
      for (int i = 0; i < 200; i++) if (bsy[i]) cnt++;
      chk("tx_busy_len", 32'(cnt), 160);
      cnt = 0;
      for (int i = n0 + 160; i < 200; i++) if (!wav[i]) cnt++;
      chk("tx_no_restart", 32'(cnt), 0);

      // Receive 8'h3C and two random bytes, acknowledging each.
      send_frame(8'h3C, 1'b1);
      model_frame(8'h3C, 1'b1);
      clk_n(4);
      check_rx("rx_3c");
      do_ack();
      for (int r = 0; r < 2; r++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1);
         model_frame(b, 1'b1);
         clk_n(4);
         check_rx("rx_rand");
         do_ack();
      end

      // Framing error: stop bit low.
      send_frame(8'h55, 1'b0);
      model_frame(8'h55, 1'b0);
      clk_n(4);
      check_rx("rx_frame");
      do_ack();

      // Overrun, then a short glitch on an idle line.
      send_frame(8'h11, 1'b1);
      model_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      model_frame(8'h22, 1'b1);
      clk_n(4);
      check_rx("rx_overrun");
      rxd_drv = 1'b0;
      clk_n(4);
      rxd_drv = 1'b1;
      clk_n(30);
      check_rx("rx_glitch");
      do_ack();

      // Loopback of every byte value with occasional reset pulses mid-frame.
      loop = 1'b1;
      clk_n(4);
      for (int v = 0; v < 256; v++) begin
         tx_data = 8'(v);
         tx_wr   = 1'b1;
         clk_n(1);
         tx_wr   = 1'b0;
         if ($urandom_range(0, 15) == 0) begin
            clk_n($urandom_range(20, 140));
            rst = 1'b0;
            clk_n($urandom_range(1, 3));
            m_data = 8'h00; m_avail = 1'b0; m_err = 1'b0;
            chk("lb_rst_txd",  32'(uart_txd), 1);
            chk("lb_rst_busy", 32'(tx_busy),  0);
            check_rx("lb_rst");
            rst = 1'b1;
            clk_n(3);
         end else begin
            ok = 0;
            for (int i = 0; i < 400; i++) begin
               clk_n(1);
               if (!tx_busy) begin
                  ok = 1;
                  break;
               end
            end
            chk("lb_tx_done", 32'(ok), 1);
            clk_n(2);
            model_frame(8'(v), 1'b1);
            check_rx($sformatf("lb_%02h", v));
            do_ack();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
